// File: rtl/seq_alu_if.sv
// Execute-stage ALU bus: request (start, opcode, operands) from the control
// FSM and the registered result/flag/handshake signals returned by the ALU.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       ALU_Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] ALU_result;
    logic [WIDTH-1:0] hi_result;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, ALU_Control, A, B,
        input  ALU_result, hi_result, zero, overflow, div_by_zero, busy, done
    );

    modport slave (
        input  start, ALU_Control, A, B,
        output ALU_result, hi_result, zero, overflow, div_by_zero, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/arithmetic/compare ops plus iterative
// shift-add multiply and restoring divide, with start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

    state_t               state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]     result_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic                 zero_reg;
    logic                 overflow_reg;
    logic                 dbz_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic [WIDTH-1:0]     sum;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     simple_res;
    logic [WIDTH-1:0]     simple_hi;
    logic                 simple_ovf;
    logic                 simple_dbz;

    always_comb begin
        sum        = bus.A + bus.B;
        diff       = bus.A - bus.B;
        simple_res = '0;
        simple_hi  = '0;
        simple_ovf = 1'b0;
        simple_dbz = 1'b0;
        case (bus.ALU_Control)
            OP_AND: simple_res = bus.A & bus.B;
            OP_OR:  simple_res = bus.A | bus.B;
            OP_ADD: begin
                simple_res = sum;
                simple_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                // Subtraction adds ~B, so the sign test uses the inverted B sign.
                simple_res = diff;
                simple_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
            OP_DIVU: begin
                // Only reached with B == 0; a non-zero divisor goes iterative.
                simple_res = '1;
                simple_hi  = bus.A;
                simple_dbz = 1'b1;
            end
            default: simple_res = '0;
        endcase
    end

    // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
    // Divide:   acc = {partial remainder, remaining dividend/quotient bits}, shift left.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_sub;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   iter_next;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, a_reg} : '0);
        mul_next  = {mul_sum, acc_reg[WIDTH-1:1]};
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_sub   = div_shift - {1'b0, b_reg};
        div_ge    = (div_shift >= {1'b0, b_reg});
        div_next  = div_ge ? {div_sub[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
        iter_next = (state_reg == ST_MUL) ? mul_next : div_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
            hi_reg       <= '0;
            zero_reg     <= 1'b1;
            overflow_reg <= 1'b0;
            dbz_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_reg <= bus.A;
                        b_reg <= bus.B;
                        if (bus.ALU_Control == OP_MUL) begin
                            acc_reg   <= {{WIDTH{1'b0}}, bus.B};
                            cnt_reg   <= CNT_W'(WIDTH);
                            busy_reg  <= 1'b1;
                            state_reg <= ST_MUL;
                        end else if (bus.ALU_Control == OP_DIVU && bus.B != '0) begin
                            acc_reg   <= {{WIDTH{1'b0}}, bus.A};
                            cnt_reg   <= CNT_W'(WIDTH);
                            busy_reg  <= 1'b1;
                            state_reg <= ST_DIV;
                        end else begin
                            result_reg   <= simple_res;
                            hi_reg       <= simple_hi;
                            zero_reg     <= (simple_res == '0);
                            overflow_reg <= simple_ovf;
                            dbz_reg      <= simple_dbz;
                            done_reg     <= 1'b1;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_reg <= iter_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == CNT_W'(1)) begin
                        result_reg   <= iter_next[WIDTH-1:0];
                        hi_reg       <= iter_next[2*WIDTH-1:WIDTH];
                        zero_reg     <= (iter_next[WIDTH-1:0] == '0);
                        overflow_reg <= 1'b0;
                        dbz_reg      <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ALU_result  = result_reg;
    assign bus.hi_result   = hi_reg;
    assign bus.zero        = zero_reg;
    assign bus.overflow    = overflow_reg;
    assign bus.div_by_zero = dbz_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle 32-bit ALU.
- Keeps the five existing 3-bit opcodes: AND, OR, ADD, SUB, SLT.
- Adds SLTU, an iterative unsigned multiply (MUL) and an iterative unsigned divide (DIVU), with start/busy/done handshake and status flags.
- Sits in the execute stage of the multi-cycle datapath; the control FSM stalls on busy.

Parameters:
- WIDTH, 32: operand and result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- ALU_Control  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 MUL, 100 DIVU, 101 SLTU, 110 SUB, 111 SLT.
- A  in  WIDTH  operand A; captured on accepted start.
- B  in  WIDTH  operand B; captured on accepted start.
- ALU_result  out  WIDTH  low result; MUL low half; DIVU quotient.
- hi_result  out  WIDTH  MUL high half; DIVU remainder; 0 for all other ops.
- zero  out  1  ALU_result == 0.
- overflow  out  1  signed overflow; ADD/SUB only, else 0.
- div_by_zero  out  1  DIVU with B=0.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse; outputs valid.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; counter=0.
  - ALU_result=0, hi_result=0, zero=1, overflow=0, div_by_zero=0, busy=0, done=0.
- Cycle numbering: start sampled high with busy=0 at the edge ending cycle 0. start while busy=1 is ignored; no queueing.
- FSM states: IDLE, MUL, DIV.
- IDLE + accepted start, simple op (AND, OR, ADD, SUB, SLT, SLTU):
  - Result computed from A/B and registered at edge 0.
  - done=1 in cycle 1; state stays IDLE.
- IDLE + accepted start, MUL:
  - Operands latched; counter=WIDTH; state MUL.
- IDLE + accepted start, DIVU with B!=0:
  - Operands latched; counter=WIDTH; state DIV.
- IDLE + accepted start, DIVU with B=0:
  - Treated as a simple op.
  - ALU_result = all ones, hi_result = A, div_by_zero=1, done in cycle 1.
- MUL:
  - Shift-add, one multiplier bit per cycle, LSB first.
  - 2*WIDTH-bit accumulator.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first.
- MUL/DIV timing:
  - busy=1 in cycles 1..WIDTH; counter decrements each cycle.
  - Final iteration at edge WIDTH writes the outputs and returns to IDLE.
  - done=1, busy=0 in cycle WIDTH+1.
- Back-to-back: start in the done cycle is accepted (busy=0).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs agree (after B inversion for SUB) and result sign differs.
  - SLT signed compare, SLTU unsigned compare; result 1 or 0 zero-extended.
  - MUL: {hi_result, ALU_result} = A*B, unsigned.
  - DIVU: quotient/remainder, unsigned.
- Flags:
  - zero, overflow and div_by_zero are registered together with ALU_result and refer to the last completed op.
  - All outputs hold their values until the next completion.
- done: high exactly one cycle per accepted start.
- Operand changes: A/B/ALU_Control changes during busy have no effect.
- Reset mid-operation: immediate abort. No done pulse; outputs return to reset values; the next start behaves as after power-up.

Test Plan:
- WIDTH=32, A=1, B=0: AND, ADD, OR, SLT each as a single start.
  - Results 0, 1, 1, 0.
  - done one cycle after each start; zero=1 for AND and SLT.
- SUB A=10, B=5 -> ALU_result=5, overflow=0.
- ADD A=0x7FFFFFFF, B=1 -> ALU_result=0x80000000, overflow=1.
- SLT A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0.
- MUL A=0xFFFFFFFF, B=2:
  - busy high cycles 1..32, done in cycle 33.
  - hi_result=1, ALU_result=0xFFFFFFFE.
  - start pulsed at cycle 5 ignored; exactly one done pulse.
- DIVU A=100, B=7 -> done cycle 33, ALU_result=14, hi_result=2.
- DIVU B=0 -> done cycle 1, ALU_result=0xFFFFFFFF, hi_result=A, div_by_zero=1.
- MUL started, rst_n low at cycle 10:
  - Outputs zero immediately; busy=0; no done.
  - After release, ADD 2+3 -> 5 with done in cycle 1.
